// File: rtl/spi_seq_multiplier_pkg.sv
// Shared definitions for the SPI multiplier peripheral: FSM state encoding,
// chip-select polarity and the default synchroniser depth.
package spi_seq_multiplier_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RX   = 3'd1,
    CALC = 3'd2,
    GAPW = 3'd3,
    TX   = 3'd4,
    HOLD = 3'd5
  } state_t;

  localparam logic CS_ACTIVE    = 1'b0;
  localparam int   DEFAULT_SYNC = 2;

endpackage

// File: rtl/spi_seq_multiplier_if.sv
// SPI slave bus of the multiplier peripheral plus its frame status outputs.
interface spi_seq_multiplier_if;
  logic SCLK;
  logic CS;
  logic MOSI;
  logic MISO;
  logic busy;
  logic done;

  modport master (output SCLK, CS, MOSI, input MISO, busy, done);
  modport slave  (input SCLK, CS, MOSI, output MISO, busy, done);
endinterface

// File: rtl/spi_seq_multiplier_core.sv
// Sequential shift-add multiplier: W CLK cycles after start the unsigned
// 2W-bit product is valid and done pulses; the result holds until the next start.
module seq_mult_core #(
  parameter int W = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product,
  output logic           done
);
  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand   <= {{W{1'b0}}, a};
        mplier  <= b;
        product <= '0;
        cnt     <= CW'(W);
      end else if (cnt != '0) begin
        if (mplier[0]) product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        done   <= (cnt == CW'(1));
      end
    end
  end

endmodule

// File: rtl/spi_seq_multiplier.sv
// SPI-slave multiplier: receives A then B (MSB first), waits GAP dummy SCLKs,
// returns the 2W-bit product. Define SPI_MAC_EN for the mode-bit accumulator.
module spi_seq_multiplier
  import spi_seq_multiplier_pkg::*;
#(
  parameter int W    = 4,
  parameter int GAP  = 2,
  parameter int SYNC = DEFAULT_SYNC
) (
  input logic                  CLK,
  input logic                  RESET,
  spi_seq_multiplier_if.slave  bus
);
`ifdef SPI_MAC_EN
  localparam int RXB = 2 * W + 1;
`else
  localparam int RXB = 2 * W;
`endif
  localparam int PW = 2 * W;
  localparam int BW = $clog2(RXB + 1);
  localparam int TW = $clog2(PW + 1);
  localparam int GW = $clog2(GAP + 2);

  logic [SYNC-1:0] sclk_sync, cs_sync, mosi_sync;
  logic            sclk_prev, cs_prev;
  logic            sclk_s, cs_s, mosi_s;
  logic            sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_s    = sclk_sync[SYNC-1];
  assign cs_s      = cs_sync[SYNC-1];
  assign mosi_s    = mosi_sync[SYNC-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = (cs_prev != CS_ACTIVE) && (cs_s == CS_ACTIVE);
  assign cs_rise   = (cs_prev == CS_ACTIVE) && (cs_s != CS_ACTIVE);

  // NOTE: non-blocking assignments so every flop in the chain samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sclk_sync <= '0;
      cs_sync   <= {SYNC{~CS_ACTIVE}};
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= ~CS_ACTIVE;
    end else begin
      sclk_sync <= {sclk_sync[SYNC-2:0], bus.SCLK};
      cs_sync   <= {cs_sync[SYNC-2:0], bus.CS};
      mosi_sync <= {mosi_sync[SYNC-2:0], bus.MOSI};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  state_t          state;
  logic [RXB-1:0]  rx_sr;
  logic [BW-1:0]   bit_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [PW-1:0]   tx_sr;
  logic [TW-1:0]   tx_cnt;
  logic            core_start, core_done;
  logic [PW-1:0]   core_product;
  logic            miso_q, busy_q, done_q;
  logic [PW-1:0]   result;

  seq_mult_core #(.W(W)) u_core (
    .CLK     (CLK),
    .RESET   (RESET),
    .start   (core_start),
    .a       (rx_sr[2*W-1:W]),
    .b       (rx_sr[W-1:0]),
    .product (core_product),
    .done    (core_done)
  );

`ifdef SPI_MAC_EN
  logic [PW-1:0] acc;
  assign result = acc;
`else
  assign result = core_product;
`endif

  assign bus.MISO = miso_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      tx_sr      <= '0;
      tx_cnt     <= '0;
      core_start <= 1'b0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SPI_MAC_EN
      acc        <= '0;
`endif
    end else begin
      core_start <= 1'b0;
      done_q     <= 1'b0;
      // Dummy rises are counted from CALC onwards so fast masters lose none.
      if ((state == CALC || state == GAPW) && sclk_rise && gap_cnt < GW'(GAP))
        gap_cnt <= gap_cnt + GW'(1);

      if (state != IDLE && cs_rise) begin
        state  <= IDLE;
        miso_q <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: if (cs_fall) begin
            bit_cnt <= '0;
            busy_q  <= 1'b1;
            miso_q  <= 1'b0;
            state   <= RX;
          end
          RX: if (sclk_rise) begin
            rx_sr <= {rx_sr[RXB-2:0], mosi_s};
            if (bit_cnt == BW'(RXB - 1)) begin
              core_start <= 1'b1;
              gap_cnt    <= '0;
              state      <= CALC;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
          CALC: if (core_done) begin
`ifdef SPI_MAC_EN
            acc <= rx_sr[RXB-1] ? acc + core_product : core_product;
`endif
            state <= GAPW;
          end
          GAPW: if (gap_cnt == GW'(GAP)) begin
            tx_sr  <= result;
            tx_cnt <= '0;
            state  <= TX;
          end
          TX: begin
            if (sclk_fall && tx_cnt != TW'(PW)) begin
              miso_q <= tx_sr[PW-1];
              tx_sr  <= tx_sr << 1;
              tx_cnt <= tx_cnt + TW'(1);
            end else if (sclk_rise && tx_cnt == TW'(PW)) begin
              done_q <= 1'b1;
              miso_q <= 1'b0;
              state  <= HOLD;
            end
          end
          HOLD:    miso_q <= 1'b0;
          default: state  <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_seq_multiplier.sv
// Self-checking bench: W=4 and W=8 peripherals on a shared SCLK/MOSI bus,
// results checked through an expected-value scoreboard queue.
module tb_spi_seq_multiplier;
  localparam time HALF = 400ns;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;

  always #5ns CLK = ~CLK;

  spi_seq_multiplier_if bus4 ();
  spi_seq_multiplier_if bus8 ();

  assign bus4.SCLK = sclk;
  assign bus4.MOSI = mosi;
  assign bus8.SCLK = sclk;
  assign bus8.MOSI = mosi;

  spi_seq_multiplier #(.W(4), .GAP(2), .SYNC(2)) dut4 (.CLK(CLK), .RESET(RESET), .bus(bus4.slave));
  spi_seq_multiplier #(.W(8), .GAP(2), .SYNC(2)) dut8 (.CLK(CLK), .RESET(RESET), .bus(bus8.slave));

  int checks = 0;
  int failures = 0;
  int done4_cnt = 0;
  int done8_cnt = 0;
  logic [31:0] exp_q[$];

  always @(posedge CLK) begin
    if (!RESET && bus4.done) done4_cnt <= done4_cnt + 1;
    if (!RESET && bus8.done) done8_cnt <= done8_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_cs(input int w, input logic v);
    if (w == 4) bus4.CS = v;
    else        bus8.CS = v;
  endtask

  function automatic logic get_miso(input int w);
    return (w == 4) ? bus4.MISO : bus8.MISO;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 4) ? bus4.busy : bus8.busy;
  endfunction

  function automatic int get_done(input int w);
    return (w == 4) ? done4_cnt : done8_cnt;
  endfunction

  task automatic shift_bit(input logic b);
    mosi = b;
    #HALF sclk = 1'b1;
    #HALF sclk = 1'b0;
  endtask

  task automatic read_bit(input int w, output logic b);
    #HALF;
    b = get_miso(w);
    sclk = 1'b1;
    #HALF sclk = 1'b0;
  endtask

  task automatic send_operands(input int w, input logic mode, input logic [15:0] a, input logic [15:0] b);
`ifdef SPI_MAC_EN
    shift_bit(mode);
`else
    if (mode) $display("note: mode bit ignored without accumulator");
`endif
    for (int i = w - 1; i >= 0; i--) shift_bit(a[i]);
    for (int i = w - 1; i >= 0; i--) shift_bit(b[i]);
    for (int g = 0; g < 2; g++) shift_bit(1'b0);
  endtask

  task automatic run_frame(input int w, input logic mode, input logic [15:0] a,
                           input logic [15:0] b, input logic [31:0] expv);
    int d0;
    logic bit_v;
    logic [31:0] res;
    exp_q.push_back(expv);
    d0 = get_done(w);
    set_cs(w, 1'b0);
    #HALF;
    check("busy_in_frame", 32'(get_busy(w)), 32'd1);
    send_operands(w, mode, a, b);
    res = '0;
    for (int i = 0; i < 2 * w; i++) begin
      read_bit(w, bit_v);
      res = {res[30:0], bit_v};
    end
    #HALF;
    check("done_once", 32'(get_done(w) - d0), 32'd1);
    check("miso_hold", 32'(get_miso(w)), 32'd0);
    shift_bit(1'b1);
    shift_bit(1'b1);
    check("miso_hold_sclk", 32'(get_miso(w)), 32'd0);
    set_cs(w, 1'b1);
    #HALF;
    check("busy_after_cs", 32'(get_busy(w)), 32'd0);
    if (exp_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
    else                   check("result", res, exp_q.pop_front());
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    logic bit_v;
    bus4.CS = 1'b1;
    bus8.CS = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    check("rst_miso4", 32'(bus4.MISO), 32'd0);
    check("rst_busy4", 32'(bus4.busy), 32'd0);
    check("rst_done4", 32'(bus4.done), 32'd0);
    check("rst_miso8", 32'(bus8.MISO), 32'd0);
    check("rst_busy8", 32'(bus8.busy), 32'd0);
    @(negedge CLK) RESET = 1'b0;
    #HALF;

    run_frame(4, 1'b0, 16'h1, 16'h6, 32'h06);
    run_frame(4, 1'b0, 16'hF, 16'hF, 32'hE1);
    run_frame(4, 1'b0, 16'h0, 16'h0, 32'h00);
    run_frame(8, 1'b0, 16'hC8, 16'h03, 32'h0258);

    // Abort after 5 operand bits.
    d0 = done4_cnt;
    bus4.CS = 1'b0;
    #HALF;
    for (int i = 0; i < 5; i++) shift_bit(i[0]);
    bus4.CS = 1'b1;
    #HALF;
    check("abort_no_done", 32'(done4_cnt - d0), 32'd0);
    check("abort_busy", 32'(bus4.busy), 32'd0);
    check("abort_miso", 32'(bus4.MISO), 32'd0);
    run_frame(4, 1'b0, 16'h2, 16'h3, 32'h06);

    // Reset in the middle of transmitting 225 = 1110_0001.
    bus4.CS = 1'b0;
    #HALF;
    send_operands(4, 1'b0, 16'hF, 16'hF);
    read_bit(4, bit_v);
    check("pre_rst_bit0", 32'(bit_v), 32'd1);
    read_bit(4, bit_v);
    check("pre_rst_bit1", 32'(bit_v), 32'd1);
    #HALF;
    check("pre_rst_miso", 32'(bus4.MISO), 32'd1);
    @(negedge CLK) RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_tx_miso", 32'(bus4.MISO), 32'd0);
    check("rst_tx_busy", 32'(bus4.busy), 32'd0);
    @(negedge CLK) RESET = 1'b0;
    bus4.CS = 1'b1;
    #(HALF * 2);
    check("post_rst_busy", 32'(bus4.busy), 32'd0);
    run_frame(4, 1'b0, 16'h6, 16'h7, 32'h2A);

`ifdef SPI_MAC_EN
    run_frame(4, 1'b0, 16'h3, 16'h5, 32'h0F);
    run_frame(4, 1'b1, 16'h2, 16'h7, 32'h1D);
    run_frame(4, 1'b1, 16'hF, 16'hF, 32'hFE);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
